cash_client_port: RTL and testbench
===================================

# cash_client_port

Request-side front end for the CAM key/value cache (`hash_cash`). It accepts single read/write/delete operations over a valid/ready request channel. Each operation becomes a probe-then-commit sequence of `cs`/`read_en`/`we`/`del` pulses on the cache port, and the result returns on a valid/ready response channel with a status code. The block also tracks cache occupancy, so full-cache and duplicate-key conditions are reported instead of silently dropped.

## Interface
- DATA_WIDTH, 32, value width; equals cache DATA_WIDTH
- KEY_WIDTH, 32, key width; equals cache KEY_WIDTH
- MEM_SIZE, 128, cache entry count; equals cache MEM_SIZE
- CNT_W, $clog2(MEM_SIZE+1), occupancy counter width (derived)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high; clock clk
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_op_i  in  2  00 read, 01 write, 10 delete, 11 illegal
- req_key_i  in  KEY_WIDTH  key
- req_data_i  in  DATA_WIDTH  write value
- rsp_valid_o  out  1  response present
- rsp_ready_i  in  1  response consumed
- rsp_data_o  out  DATA_WIDTH  read value; 0 unless read hit
- rsp_status_o  out  3  0 OK, 1 MISS, 2 DUP, 3 FULL, 4 ILLEGAL
- count_o  out  CNT_W  current number of occupied cache entries
- cash_cs_o, cash_we_o, cash_read_en_o, cash_del_o  out  1 each  cache strobes
- cash_key_write_o, cash_key_read_o  out  KEY_WIDTH  cache keys
- cash_data_o  out  DATA_WIDTH  cache data_in
- cash_data_i  in  DATA_WIDTH  cache data_out
- cash_valid_i  in  1  cache valid_o
- cash_error_i  in  2  cache error; bit 0 = duplicate-key write

## Operation
- FSM states: IDLE, PROBE, WAIT, COMMIT, RESP. One operation outstanding.
- **IDLE**
  - req_ready_o=1.
  - On handshake, latch op, key and data.
  - Illegal op goes directly to RESP with ILLEGAL; otherwise go to PROBE.
- **PROBE**
  - Drive cs=1, read_en=1, key_read_o = latched key.
  - All other strobes are 0.
- **WAIT**
  - All strobes are 0.
  - Sample hit = cash_valid_i, which is the cache's registered result of PROBE.
  - Read: go to RESP. Hit gives status OK with rsp_data = cash_data_i. Miss gives status MISS with data 0.
  - Write with hit: go to RESP with DUP.
  - Write with miss and count==MEM_SIZE: go to RESP with FULL.
  - Write with miss and space available: go to COMMIT.
  - Delete with miss: go to RESP with MISS.
  - Delete with hit: go to COMMIT.
- **COMMIT**
  - Write: drive cs=1, we=1, key_write_o = key, data_o = data.
    - If cash_error_i[0]=1 in the same cycle, status is DUP and count is unchanged.
    - Otherwise status is OK and count increments by 1.
  - Delete: drive cs=1, del=1, key_write_o = key; status OK, count decrements by 1.
  - Next state is RESP.
- **RESP**
  - rsp_valid_o=1; data and status are held stable.
  - Go to IDLE on rsp_ready_i.
- Strobes are 0 in every state except PROBE and COMMIT. Key, data and status outputs are registered.
- count saturates: it never exceeds MEM_SIZE and never underflows below 0. A violation indicates a cache/port mismatch and is flagged by an assertion.
- Reset
  - This block and the cache share reset.
  - Outputs after reset: req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_status_o=0, count_o=0.
  - All cash_* outputs are 0 and state is IDLE.
  - Reset asserted mid-operation aborts it without a response. The cache contents are cleared by the same reset, so count=0 stays consistent.

## Timing
- Request handshake at edge of cycle A.
- PROBE occupies A+1 and WAIT occupies A+2.
- Read, and any write or delete that skips COMMIT: rsp_valid_o is high in A+3.
- Write or delete that goes through COMMIT: COMMIT is A+3, rsp_valid_o is high in A+4.
- Illegal op: rsp_valid_o is high in A+1.
- count_o updates on the edge that ends COMMIT.
- rsp_ready_i held low stalls RESP indefinitely with outputs stable. req_ready_o stays 0 throughout.
- Back-to-back throughput: the next request can be accepted in the cycle after the RESP handshake.

## Structure
- cash_pkg holds:
  - op_e (READ, WRITE, DELETE, ILLEGAL)
  - status_e (OK, MISS, DUP, FULL, ILLEGAL)
  - state_e (the five FSM states)
- No sub-modules: a single FSM plus counter in one file.
- The top-level test wrapper instantiates cash_client_port connected to hash_cash.

## Test plan
- Write key 0x10 data 0xAAAA, then read 0x10 -> write: OK with count 1, response in A+4; read: OK with data 0xAAAA, response in A+3.
- Read key 0x99 from an empty cache -> status MISS, data 0, count 0.
- Write 0x10 twice -> second write: DUP with no COMMIT strobe, count stays 1. Delete 0x10 -> OK, count 0. Delete 0x10 again -> MISS.
- MEM_SIZE=4: write keys 1..4, then key 5 -> the first four are OK and count reaches 4; key 5 gives FULL with no we pulse. Delete key 2 and write key 5 -> OK, count 4.
- Illegal op 11 -> ILLEGAL at A+1, no cache strobes. Hold rsp_ready_i low for 5 cycles -> response stable and req_ready_o=0.
- Assert reset during COMMIT of a write -> the next cycle shows IDLE, count 0, rsp_valid_o 0, and a subsequent read of that key returns MISS.

Source files
------------

// File: rtl/cash_pkg.sv
// cash_pkg: shared operation, status and FSM state encodings for the hash_cash client port
package cash_pkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_DELETE, OP_ILLEGAL} op_e;
  typedef enum logic [2:0] {S_OK, S_MISS, S_DUP, S_FULL, S_ILLEGAL} status_e;
  typedef enum logic [2:0] {IDLE, PROBE, WAIT, COMMIT, RESP} state_e;
endpackage

// File: rtl/cash_client_port_if.sv
// cash_client_port_if: request/response channels, occupancy and hash_cash strobe bundle
interface cash_client_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 32,
  parameter int MEM_SIZE = 128
);
  localparam int CNT_W = $clog2(MEM_SIZE + 1);
  logic req_valid_i;
  logic req_ready_o;
  logic [1:0] req_op_i;
  logic [KEY_WIDTH-1:0] req_key_i;
  logic [DATA_WIDTH-1:0] req_data_i;
  logic rsp_valid_o;
  logic rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_data_o;
  logic [2:0] rsp_status_o;
  logic [CNT_W-1:0] count_o;
  logic cash_cs_o;
  logic cash_we_o;
  logic cash_read_en_o;
  logic cash_del_o;
  logic [KEY_WIDTH-1:0] cash_key_write_o;
  logic [KEY_WIDTH-1:0] cash_key_read_o;
  logic [DATA_WIDTH-1:0] cash_data_o;
  logic [DATA_WIDTH-1:0] cash_data_i;
  logic cash_valid_i;
  logic [1:0] cash_error_i;
  modport slave (
    input req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i, cash_data_i, cash_valid_i, cash_error_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o, count_o,
    output cash_cs_o, cash_we_o, cash_read_en_o, cash_del_o, cash_key_write_o, cash_key_read_o, cash_data_o
  );
  modport master (
    output req_valid_i, req_op_i, req_key_i, req_data_i, rsp_ready_i, cash_data_i, cash_valid_i, cash_error_i,
    input req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o, count_o,
    input cash_cs_o, cash_we_o, cash_read_en_o, cash_del_o, cash_key_write_o, cash_key_read_o, cash_data_o
  );
endinterface

// File: rtl/cash_client_port.sv
// cash_client_port: turns single read/write/delete requests into probe-then-commit hash_cash cycles
module cash_client_port
  import cash_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEY_WIDTH = 32,
  parameter int MEM_SIZE = 128
) (
  input logic clk,
  input logic reset,
  cash_client_port_if.slave bus
);
  localparam int CNT_W = $clog2(MEM_SIZE + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_SIZE);
  state_e state, state_n;
  op_e op, op_n;
  status_e status, status_n;
  logic [KEY_WIDTH-1:0] key, key_n, key_rd, key_rd_n, key_wr, key_wr_n;
  logic [DATA_WIDTH-1:0] data, data_n, rsp_data, rsp_data_n, cdata, cdata_n;
  logic [CNT_W-1:0] count, count_n;
  logic cs, cs_n, we, we_n, rd, rd_n, del, del_n, hit, dup;
  assign hit = bus.cash_valid_i;
  assign dup = op == OP_WRITE && bus.cash_error_i[0];
  // next state, response and occupancy; cache strobes are derived from the state being entered so they leave a register
  always_comb begin
    state_n = state;
    op_n = op;
    key_n = key;
    data_n = data;
    rsp_data_n = rsp_data;
    status_n = status;
    count_n = count;
    case (state)
      IDLE: if (bus.req_valid_i) begin
        op_n = op_e'(bus.req_op_i);
        key_n = bus.req_key_i;
        data_n = bus.req_data_i;
        rsp_data_n = '0;
        status_n = S_ILLEGAL;
        state_n = op_n == OP_ILLEGAL ? RESP : PROBE;
      end
      PROBE: state_n = WAIT;
      WAIT: begin
        rsp_data_n = op == OP_READ && hit ? bus.cash_data_i : '0;
        status_n = hit ? (op == OP_WRITE ? S_DUP : S_OK) : (op == OP_WRITE ? S_FULL : S_MISS);
        state_n = (op == OP_WRITE ? !hit && count != FULL_CNT : op == OP_DELETE && hit) ? COMMIT : RESP;
      end
      COMMIT: begin
        status_n = dup ? S_DUP : S_OK;
        count_n = op == OP_WRITE ? (dup || count == FULL_CNT ? count : count + CNT_W'(1))
                                 : (count == '0 ? count : count - CNT_W'(1));
        state_n = RESP;
      end
      RESP: state_n = bus.rsp_ready_i ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
    cs_n = state_n == PROBE || state_n == COMMIT;
    rd_n = state_n == PROBE;
    we_n = state_n == COMMIT && op_n == OP_WRITE;
    del_n = state_n == COMMIT && op_n == OP_DELETE;
    key_rd_n = rd_n ? key_n : '0;
    key_wr_n = state_n == COMMIT ? key_n : '0;
    cdata_n = we_n ? data_n : '0;
  end
  // state, latched request, response and cache-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= OP_READ;
      key <= '0;
      data <= '0;
      rsp_data <= '0;
      status <= S_OK;
      count <= '0;
      cs <= 1'b0;
      we <= 1'b0;
      rd <= 1'b0;
      del <= 1'b0;
      key_rd <= '0;
      key_wr <= '0;
      cdata <= '0;
    end else begin
      state <= state_n;
      op <= op_n;
      key <= key_n;
      data <= data_n;
      rsp_data <= rsp_data_n;
      status <= status_n;
      count <= count_n;
      cs <= cs_n;
      we <= we_n;
      rd <= rd_n;
      del <= del_n;
      key_rd <= key_rd_n;
      key_wr <= key_wr_n;
      cdata <= cdata_n;
    end
  end
  assign bus.req_ready_o = state == IDLE;
  assign bus.rsp_valid_o = state == RESP;
  assign bus.rsp_data_o = rsp_data;
  assign bus.rsp_status_o = status;
  assign bus.count_o = count;
  assign bus.cash_cs_o = cs;
  assign bus.cash_we_o = we;
  assign bus.cash_read_en_o = rd;
  assign bus.cash_del_o = del;
  assign bus.cash_key_read_o = key_rd;
  assign bus.cash_key_write_o = key_wr;
  assign bus.cash_data_o = cdata;
  // a commit that would push occupancy past capacity or below zero means the cache and this port disagree
  assert property (@(posedge clk) disable iff (reset)
    state == COMMIT |-> (op == OP_WRITE ? bus.cash_error_i[0] || count != FULL_CNT : count != '0));
endmodule

// File: tb/tb_cash_client_port.sv
// tb_cash_client_port: directed and randomized checks of the client port against a cache model and reference map
module tb_cash_client_port;
  localparam int DW = 32;
  localparam int KW = 32;
  localparam int MS = 4;
  localparam int CW = $clog2(MS + 1);
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  cash_client_port_if #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MEM_SIZE(MS)) bus ();
  cash_client_port #(.DATA_WIDTH(DW), .KEY_WIDTH(KW), .MEM_SIZE(MS)) dut (.clk(clk), .reset(reset), .bus(bus));
  int n_checks = 0;
  int n_fail = 0;
  bit inject_dup = 1'b0;
  logic [DW-1:0] ref_mem [logic [KW-1:0]];
  logic [2:0] o_st;
  logic [DW-1:0] o_rd;
  int o_lat, o_cs, o_we, o_del;
  bit o_held;
  // small behavioural CAM standing in for hash_cash: registered probe result, duplicate error during a write
  logic [MS-1:0] cv;
  logic [KW-1:0] ck [MS];
  logic [DW-1:0] cd [MS];
  function automatic int find(input logic [KW-1:0] k);
    for (int i = 0; i < MS; i++) if (cv[i] && ck[i] == k) return i;
    return -1;
  endfunction
  function automatic int free_slot();
    for (int i = 0; i < MS; i++) if (!cv[i]) return i;
    return -1;
  endfunction
  assign bus.cash_error_i = {1'b0, bus.cash_cs_o && bus.cash_we_o && (inject_dup || find(bus.cash_key_write_o) >= 0)};
  always @(posedge clk) begin
    if (reset) begin
      cv <= '0;
      bus.cash_valid_i <= 1'b0;
      bus.cash_data_i <= '0;
    end else begin
      bus.cash_valid_i <= bus.cash_cs_o && bus.cash_read_en_o && find(bus.cash_key_read_o) >= 0;
      bus.cash_data_i <= (bus.cash_cs_o && bus.cash_read_en_o && find(bus.cash_key_read_o) >= 0) ? cd[find(bus.cash_key_read_o)] : '0;
      if (bus.cash_cs_o && bus.cash_we_o && !bus.cash_error_i[0] && free_slot() >= 0) begin
        cv[free_slot()] <= 1'b1;
        ck[free_slot()] <= bus.cash_key_write_o;
        cd[free_slot()] <= bus.cash_data_o;
      end
      if (bus.cash_cs_o && bus.cash_del_o && find(bus.cash_key_write_o) >= 0) cv[find(bus.cash_key_write_o)] <= 1'b0;
    end
  end
  // reference behaviour: status, read data and response latency from the operation rules alone
  function automatic void predict(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d, input bit inj,
                                  output logic [2:0] st, output logic [DW-1:0] rd, output int lat);
    bit hit = ref_mem.exists(k);
    rd = '0;
    lat = 3;
    if (op == 2'd3) begin st = 3'd4; lat = 1; end
    else if (op == 2'd0) begin st = hit ? 3'd0 : 3'd1; if (hit) rd = ref_mem[k]; end
    else if (op == 2'd1) begin
      if (hit) st = 3'd2;
      else if (ref_mem.num() == MS) st = 3'd3;
      else begin lat = 4; st = inj ? 3'd2 : 3'd0; if (!inj) ref_mem[k] = d; end
    end else begin
      st = hit ? 3'd0 : 3'd1;
      if (hit) begin lat = 4; ref_mem.delete(k); end
    end
  endfunction
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    inject_dup = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ref_mem.delete();
  endtask
  // one request: records latency (cycles after the accepting edge), strobe pulses and response stability
  task automatic issue(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d, input int stall);
    int w = 0;
    o_cs = 0; o_we = 0; o_del = 0; o_held = 1'b1;
    while (!bus.req_ready_o && w < 20) begin @(negedge clk); w++; end
    n_checks++;
    if (w == 20) begin n_fail++; $display("FAIL req_ready_wait: req_ready_o stayed %0b, want 1", bus.req_ready_o); end
    bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_key_i = k; bus.req_data_i = d;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    o_lat = 1;
    while (!bus.rsp_valid_o && o_lat < 20) begin
      o_cs += int'(bus.cash_cs_o); o_we += int'(bus.cash_we_o); o_del += int'(bus.cash_del_o);
      @(negedge clk);
      o_lat++;
    end
    o_st = bus.rsp_status_o;
    o_rd = bus.rsp_data_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      o_held &= bus.rsp_valid_o && !bus.req_ready_o && bus.rsp_status_o == o_st && bus.rsp_data_o == o_rd && !bus.cash_cs_o;
    end
    bus.rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.rsp_ready_i = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o} !== 2'b10) begin n_fail++; $display("FAIL reset_handshake: ready/valid %b, want 10", {bus.req_ready_o, bus.rsp_valid_o}); end
    n_checks++;
    if ({bus.rsp_data_o, bus.rsp_status_o, bus.count_o} !== '0) begin n_fail++; $display("FAIL reset_rsp: data %h status %0d count %0d, want 0", bus.rsp_data_o, bus.rsp_status_o, bus.count_o); end
    n_checks++;
    if ({bus.cash_cs_o, bus.cash_we_o, bus.cash_read_en_o, bus.cash_del_o, bus.cash_key_write_o, bus.cash_key_read_o, bus.cash_data_o} !== '0) begin
      n_fail++; $display("FAIL reset_cash: cache outputs not all zero, want zero");
    end
  endtask
  task automatic test_read_miss();
    issue(2'd0, 32'h99, 32'h0, 0);
    n_checks++;
    if ({o_st, o_rd, bus.count_o} !== {3'd1, 32'h0, CW'(0)}) begin n_fail++; $display("FAIL read_miss: status %0d data %h count %0d, want 1 0 0", o_st, o_rd, bus.count_o); end
    n_checks++;
    if (o_lat != 3 || o_cs != 1 || o_we != 0) begin n_fail++; $display("FAIL read_miss_timing: lat %0d cs %0d we %0d, want 3 1 0", o_lat, o_cs, o_we); end
  endtask
  task automatic test_write_read();
    issue(2'd1, 32'h10, 32'hAAAA, 0);
    n_checks++;
    if (o_st !== 3'd0 || o_lat != 4 || o_we != 1 || bus.count_o !== CW'(1)) begin
      n_fail++; $display("FAIL write_ok: status %0d lat %0d we %0d count %0d, want 0 4 1 1", o_st, o_lat, o_we, bus.count_o);
    end
    n_checks++;
    if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL back_to_back: req_ready_o %b after response, want 1", bus.req_ready_o); end
    issue(2'd0, 32'h10, 32'h0, 0);
    n_checks++;
    if (o_st !== 3'd0 || o_rd !== 32'hAAAA || o_lat != 3) begin n_fail++; $display("FAIL read_hit: status %0d data %h lat %0d, want 0 aaaa 3", o_st, o_rd, o_lat); end
  endtask
  task automatic test_dup_delete();
    issue(2'd1, 32'h10, 32'h5555, 0);
    n_checks++;
    if (o_st !== 3'd2 || o_we != 0 || o_lat != 3 || bus.count_o !== CW'(1)) begin
      n_fail++; $display("FAIL write_dup: status %0d we %0d lat %0d count %0d, want 2 0 3 1", o_st, o_we, o_lat, bus.count_o);
    end
    issue(2'd2, 32'h10, 32'h0, 0);
    n_checks++;
    if (o_st !== 3'd0 || o_del != 1 || o_lat != 4 || bus.count_o !== CW'(0)) begin
      n_fail++; $display("FAIL delete_hit: status %0d del %0d lat %0d count %0d, want 0 1 4 0", o_st, o_del, o_lat, bus.count_o);
    end
    issue(2'd2, 32'h10, 32'h0, 0);
    n_checks++;
    if (o_st !== 3'd1 || o_del != 0 || o_lat != 3) begin n_fail++; $display("FAIL delete_miss: status %0d del %0d lat %0d, want 1 0 3", o_st, o_del, o_lat); end
  endtask
  task automatic test_full();
    bit all_ok = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      issue(2'd1, KW'(k), DW'(k * 16'h111), 0);
      all_ok &= o_st == 3'd0;
    end
    n_checks++;
    if (!all_ok || bus.count_o !== CW'(4)) begin n_fail++; $display("FAIL fill: all_ok %0b count %0d, want 1 4", all_ok, bus.count_o); end
    issue(2'd1, 32'd5, 32'h5, 0);
    n_checks++;
    if (o_st !== 3'd3 || o_we != 0 || o_lat != 3 || bus.count_o !== CW'(4)) begin
      n_fail++; $display("FAIL write_full: status %0d we %0d lat %0d count %0d, want 3 0 3 4", o_st, o_we, o_lat, bus.count_o);
    end
    issue(2'd2, 32'd2, 32'h0, 0);
    issue(2'd1, 32'd5, 32'h5, 0);
    n_checks++;
    if (o_st !== 3'd0 || bus.count_o !== CW'(4)) begin n_fail++; $display("FAIL refill: status %0d count %0d, want 0 4", o_st, bus.count_o); end
    issue(2'd0, 32'd3, 32'h0, 0);
    n_checks++;
    if (o_st !== 3'd0 || o_rd !== 32'h333) begin n_fail++; $display("FAIL read_after_fill: status %0d data %h, want 0 333", o_st, o_rd); end
  endtask
  task automatic test_illegal_stall();
    issue(2'd3, 32'h7, 32'h7, 5);
    n_checks++;
    if (o_st !== 3'd4 || o_lat != 1 || o_cs != 0 || o_rd !== 32'h0) begin
      n_fail++; $display("FAIL illegal: status %0d lat %0d cs %0d data %h, want 4 1 0 0", o_st, o_lat, o_cs, o_rd);
    end
    n_checks++;
    if (!o_held) begin n_fail++; $display("FAIL stall_hold: response changed or req_ready_o rose while stalled, want stable"); end
  endtask
  task automatic test_inject_dup();
    do_reset();
    inject_dup = 1'b1;
    issue(2'd1, 32'h20, 32'h1234, 0);
    inject_dup = 1'b0;
    n_checks++;
    if (o_st !== 3'd2 || o_lat != 4 || o_we != 1 || bus.count_o !== CW'(0)) begin
      n_fail++; $display("FAIL commit_dup: status %0d lat %0d we %0d count %0d, want 2 4 1 0", o_st, o_lat, o_we, bus.count_o);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    bus.req_valid_i = 1'b1; bus.req_op_i = 2'd1; bus.req_key_i = 32'h77; bus.req_data_i = 32'hBEEF;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.cash_we_o !== 1'b1) begin n_fail++; $display("FAIL reach_commit: cash_we_o %b, want 1", bus.cash_we_o); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ref_mem.delete();
    n_checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.count_o} !== {1'b1, 1'b0, CW'(0)}) begin
      n_fail++; $display("FAIL reset_mid: ready %b valid %b count %0d, want 1 0 0", bus.req_ready_o, bus.rsp_valid_o, bus.count_o);
    end
    issue(2'd0, 32'h77, 32'h0, 0);
    n_checks++;
    if (o_st !== 3'd1) begin n_fail++; $display("FAIL reset_mid_read: status %0d, want 1", o_st); end
  endtask
  task automatic test_random();
    logic [2:0] es;
    logic [DW-1:0] ed;
    int el;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      logic [1:0] op = $urandom_range(9) < 1 ? 2'd3 : 2'($urandom_range(2));
      logic [KW-1:0] k = KW'($urandom_range(6, 1));
      logic [DW-1:0] d = $urandom;
      int stall = $urandom_range(2);
      bit inj = $urandom_range(15) == 0;
      inject_dup = inj;
      predict(op, k, d, inj, es, ed, el);
      issue(op, k, d, stall);
      inject_dup = 1'b0;
      n_checks++;
      if (o_st !== es || o_rd !== ed || o_lat != el) begin
        n_fail++; $display("FAIL rand_rsp op %0d key %0d: status %0d data %h lat %0d, want %0d %h %0d", op, k, o_st, o_rd, o_lat, es, ed, el);
      end
      n_checks++;
      if (bus.count_o !== CW'(ref_mem.num()) || !o_held) begin
        n_fail++; $display("FAIL rand_count op %0d key %0d: count %0d held %0b, want %0d 1", op, k, bus.count_o, o_held, ref_mem.num());
      end
    end
  endtask
  initial begin
    bus.req_valid_i = 1'b0; bus.req_op_i = '0; bus.req_key_i = '0; bus.req_data_i = '0; bus.rsp_ready_i = 1'b0;
    test_reset();
    test_read_miss();
    test_write_read();
    test_dup_delete();
    test_full();
    test_illegal_stall();
    test_inject_dup();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
